bcd_seven_segment_driver: RTL and testbench

BCD_SEVEN_SEGMENT_DRIVER -- requirements
Module: bcd_seven_segment_driver

---
 rtl/bcd_seven_segment_driver.sv | 147 ++++++++++++++
 tb/tb_bcd_seven_segment_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seven_segment_driver.sv
// Binary to multi-digit 7-segment driver: a sequential double-dabble conversion
// followed by a registered segment decode with leading-zero blanking and overflow dashes.
module bcd_seven_segment_driver #(
  parameter int DATA_W     = 8,
  parameter int DIGITS     = 3,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  // floor(DATA_W*log10(2))+1 decimal digits cover 2^DATA_W-1; never fewer than DIGITS.
  localparam int NBCD_RAW = (DATA_W * 301) / 1000 + 1;
  localparam int NBCD     = (NBCD_RAW > DIGITS) ? NBCD_RAW : DIGITS;
  localparam int CNT_W    = $clog2(DATA_W + 1);
  localparam logic [6:0] SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                state_q;
  logic [DATA_W-1:0]     bin_q;
  logic [4*NBCD-1:0]     bcd_q;
  logic [4*NBCD-1:0]     bcd_adj;
  logic [4*NBCD-1:0]     bcd_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [7*DIGITS-1:0]   seg_q;
  logic [7*DIGITS-1:0]   seg_d;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  lead;
  logic [3:0]            digit;
  logic [6:0]            code;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b0111111;
      4'd1:    c = 7'b0000110;
      4'd2:    c = 7'b1011011;
      4'd3:    c = 7'b1001111;
      4'd4:    c = 7'b1100110;
      4'd5:    c = 7'b1101101;
      4'd6:    c = 7'b1111101;
      4'd7:    c = 7'b0000111;
      4'd8:    c = 7'b1111111;
      4'd9:    c = 7'b1101111;
      default: c = SEG_DASH;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] c);
    return (ACTIVE_LOW != 0) ? ~c : c;
  endfunction

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NBCD; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[4*NBCD-2:0], bin_q[DATA_W-1]};
  end

  // Decode from the top digit down so "lead" tracks whether only zeros were seen so far.
  always_comb begin
    ovf_d = 1'b0;
    for (int k = DIGITS; k < NBCD; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0)
        ovf_d = 1'b1;
    end
    lead  = 1'b1;
    digit = 4'd0;
    code  = 7'd0;
    seg_d = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit = bcd_q[4*k +: 4];
      if (digit != 4'd0 || k == 0)
        lead = 1'b0;
      if (ovf_d)
        code = SEG_DASH;
      else if (BLANK_LZ != 0 && lead)
        code = 7'd0;
      else
        code = seg_code(digit);
      seg_d[7*k +: 7] = polarity(code);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= {DIGITS{SEG_OFF}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= value;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1))
            state_q <= LOAD;
        end
        LOAD: begin
          seg_q   <= seg_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_bcd_seven_segment_driver.sv
// Scoreboard bench for bcd_seven_segment_driver: a 3-digit instance and a 2-digit
// instance share clock and reset; monitors pop expected results on every done pulse.
module tb_bcd_seven_segment_driver;

  localparam logic [6:0] D0   = 7'b1000000;
  localparam logic [6:0] D1   = 7'b1111001;
  localparam logic [6:0] D2   = 7'b0100100;
  localparam logic [6:0] D4   = 7'b0011001;
  localparam logic [6:0] D5   = 7'b0010010;
  localparam logic [6:0] D7   = 7'b1111000;
  localparam logic [6:0] D9   = 7'b0010000;
  localparam logic [6:0] BL   = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  typedef struct {
    logic [20:0] seg;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [7:0]  value, value2;
  logic        busy, done, overflow;
  logic        busy2, done2, overflow2;
  logic [20:0] seg;
  logic [13:0] seg2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_seven_segment_driver #(.DATA_W(8), .DIGITS(3), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .overflow(overflow), .seg(seg)
  );

  bcd_seven_segment_driver #(.DATA_W(8), .DIGITS(2), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .value(value2),
    .busy(busy2), .done(done2), .overflow(overflow2), .seg(seg2)
  );

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done3: got done with seg=%b, required no done", seg);
      end else begin
        e = q1.pop_front();
        if (seg !== e.seg || overflow !== e.ovf) begin
          errors++;
          $display("FAIL result3: got seg=%b ovf=%b, required seg=%b ovf=%b", seg, overflow, e.seg, e.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done2: got done with seg=%b, required no done", seg2);
      end else begin
        e = q2.pop_front();
        if (seg2 !== e.seg[13:0] || overflow2 !== e.ovf) begin
          errors++;
          $display("FAIL result2: got seg=%b ovf=%b, required seg=%b ovf=%b", seg2, overflow2, e.seg[13:0], e.ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic expect_result(input int sel, input logic [20:0] es, input logic eo);
    exp_t e;
    e.seg = es;
    e.ovf = eo;
    if (sel == 0) q1.push_back(e);
    else          q2.push_back(e);
  endtask

  // Waits for done, counting cycles since the start edge and cycles with busy high.
  task automatic wait_done(input int sel, output int lat, output int nbusy);
    bit got;
    got   = 0;
    lat   = 0;
    nbusy = 0;
    for (int i = 1; i <= 30 && !got; i++) begin
      if ((sel == 0) ? busy : busy2) nbusy++;
      @(posedge clk); #1;
      lat = i;
      if ((sel == 0) ? done : done2) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within 30 cycles, required done");
    end
  endtask

  task automatic convert(input int sel, input logic [7:0] v, input logic [20:0] es, input logic eo);
    int lat, nbusy;
    expect_result(sel, es, eo);
    if (sel == 0) begin start = 1'b1; value = v; end
    else          begin start2 = 1'b1; value2 = v; end
    @(posedge clk); #1;
    start  = 1'b0;
    start2 = 1'b0;
    wait_done(sel, lat, nbusy);
    chk("latency", lat, 9);
    chk("busy_cycles", nbusy, 9);
  endtask

  initial begin
    int lat, nbusy;
    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    value  = 8'd0;
    value2 = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seg3", {11'd0, seg}, {11'd0, 21'h1FFFFF});
    chk("reset_seg2", {18'd0, seg2}, {18'd0, 14'h3FFF});
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    // Back-to-back conversions: each start lands in the IDLE cycle right after done.
    convert(0, 8'd0,   {BL, BL, D0}, 1'b0);
    convert(0, 8'd24,  {BL, D2, D4}, 1'b0);
    convert(0, 8'd255, {D2, D5, D5}, 1'b0);
    convert(0, 8'd7,   {BL, BL, D7}, 1'b0);
    convert(0, 8'd10,  {BL, D1, D0}, 1'b0);
    convert(0, 8'd105, {D1, D0, D5}, 1'b0);
    chk("hold_seg", {11'd0, seg}, {11'd0, D1, D0, D5});

    // Start while busy is ignored; value changes mid-conversion do not leak in.
    expect_result(0, {D1, D0, D0}, 1'b0);
    start = 1'b1; value = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; value = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, lat, nbusy);
    repeat (12) begin @(posedge clk); #1; end

    // Reset mid-conversion aborts it; no done may follow.
    start = 1'b1; value = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("abort_seg", {11'd0, seg}, {11'd0, 21'h1FFFFF});
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    convert(0, 8'd9, {BL, BL, D9}, 1'b0);
    repeat (12) begin @(posedge clk); #1; end

    // Two-digit instance: overflow dashes, then recovery.
    convert(1, 8'd200, {7'd0, DASH, DASH}, 1'b1);
    chk("ovf_hold", {31'd0, overflow2}, 32'd1);
    convert(1, 8'd99, {7'd0, D9, D9}, 1'b0);
    convert(1, 8'd7, {7'd0, BL, D7}, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    chk("queue3_empty", q1.size(), 0);
    chk("queue2_empty", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
